bids22_result_log: RTL and testbench
====================================

Name: bids22_result_log

Overview:
Downstream stage of the bids22 auction FSM; consumes its round-level outputs.
- Counts acknowledged bids while a round is active.
- On each round-over event, captures winner and max bid into a result record.
- Buffers records in a FIFO, drained by the host over a valid/ready handshake.
- Gives software an ordered, lossless (or explicitly flagged lossy) history of auction rounds.

Parameters:
DATAWIDTH, 32, width of max_bid and the record's max-bid field
NUMBIDDERS, 3, number of bidders (width of win/bid_ack)
DEPTH, 8, FIFO entries; power of two, >=2
RIDWIDTH, 16, round-id counter width

Ports:
clk  input  1  clock
reset_n  input  1  async active-low reset
round_active  input  1  high while the FSM is in ROUNDSTARTED
round_over  input  1  FSM cout.roundOver
max_bid  input  DATAWIDTH  FSM cout.maxBid, valid while round_over=1
win  input  NUMBIDDERS  per-bidder win bits from the FSM
bid_ack  input  NUMBIDDERS  per-bidder ack bits from the FSM
clr  input  1  sync flush of FIFO, counters and flags
res_valid  output  1  head record available
res_ready  input  1  host accepts head record
res_round_id  output  RIDWIDTH  round sequence number
res_winner_id  output  max(1,$clog2(NUMBIDDERS))  winning bidder index
res_no_winner  output  1  no win bit was set
res_multi_win  output  1  more than one win bit was set
res_max_bid  output  DATAWIDTH  captured max bid
res_bid_count  output  8  acked bids this round, saturating
fifo_count  output  $clog2(DEPTH)+1  occupancy
overflow  output  1  sticky: a record was dropped
drop_count  output  8  dropped records, saturating

Behaviour:
Reset (async, reset_n low):
- All outputs 0; FIFO empty; round-id counter 0; bid accumulator 0; round_over_q 0.

Capture:
- capture = round_over & ~round_over_q (rising edge; round_over_q is registered).
- A held-high round_over produces exactly one record.

Bid accumulator:
- Each cycle round_active=1, add popcount(bid_ack), saturating at 255.
- Cleared on the cycle after capture, so the next round starts at 0.
- bid_ack while round_active=0 is ignored.

Record fields at capture:
- round_id = current counter value; counter then increments and wraps 2^RIDWIDTH-1 -> 0.
- win=0: no_winner=1, winner_id=0.
- win has more than one bit set: multi_win=1, winner_id = lowest set index.
- max_bid: sampled max_bid.
- bid_count: accumulator value including any acks in the capture cycle itself.

FIFO (first-word-fall-through):
- Latency: capture in cycle N -> res_valid=1 with the record in cycle N+1 if the FIFO was empty.
- pop = res_valid & res_ready.
- Head fields stay stable while res_valid=1 & res_ready=0.
- Full & capture & ~pop: record dropped; overflow<=1; drop_count++ (saturating); round_id still increments.
- Full & capture & pop: both occur; count unchanged; no drop.
- Empty: res_valid=0 and pop is impossible; capture plus res_ready on an empty FIFO simply pushes.
- Pointers wrap modulo DEPTH; fifo_count is 0..DEPTH.

clr (synchronous):
- Empties the FIFO; zeroes round-id, accumulator, overflow and drop_count.
- Has priority over a same-cycle capture and pop; that record is discarded without setting overflow.
- round_over_q still updates, so a held round_over does not re-capture after clr.

Reset mid-operation:
- Immediate return to reset state; partial round data is lost.

No internal state machine beyond the FIFO and counters. Outputs are registered or driven directly from FIFO storage, with no combinational input-to-output path except res_valid/head.

Decomposition:
- bids22defs gains:
  - typedef bids22_result_t: packed struct {round_id, winner_id, no_winner, multi_win, max_bid, bid_count}.
  - constant RESULT_CNT_MAX = 8'hFF.
- Natural sub-module: bids22_result_fifo, a generic parameterized FWFT sync FIFO (push/pop/full/empty/count) storing bids22_result_t.
- Capture, accumulator and flag logic stay in the top.

Test Plan:
- 3 cycles round_active with bid_ack=3'b011,3'b100,3'b000; round_over=1 with win=3'b010, max_bid=40 -> next cycle res_valid=1, winner_id=1, bid_count=3, max_bid=40, round_id=0.
- round_over held high 4 cycles -> exactly one record; fifo_count=1.
- 9 rounds with res_ready=0 (DEPTH=8) -> fifo_count=8, overflow=1, drop_count=1; drained round_ids 0..7.
- FIFO full; capture and pop in the same cycle -> no drop; count stays 8; the new record is last.
- win=3'b000 -> no_winner=1, winner_id=0. win=3'b110 -> multi_win=1, winner_id=1.
- clr asserted in the same cycle as capture with 3 entries queued -> fifo_count=0, res_valid=0, overflow=0; next round logs round_id=0.

Source files
------------

// File: rtl/bids22_result_log_pkg.sv
// bids22 result-log shared types and constants.
// The result record layout is fixed by the default widths below.
package bids22_result_log_pkg;

  localparam int B22_DW    = 32;
  localparam int B22_NB    = 3;
  localparam int B22_DEPTH = 8;
  localparam int B22_RIDW  = 16;
  localparam int B22_WIDW  =
    (B22_NB > 1) ? $clog2(B22_NB) : 1;

  localparam logic [7:0] RESULT_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic [B22_RIDW-1:0] round_id;
    logic [B22_WIDW-1:0] winner_id;
    logic                no_winner;
    logic                multi_win;
    logic [B22_DW-1:0]   max_bid;
    logic [7:0]          bid_count;
  } bids22_result_t;

endpackage

// File: rtl/bids22_result_fifo.sv
// First-word-fall-through sync FIFO of bids22 result records.
// clr empties it and overrides any same-cycle push or pop.
module bids22_result_fifo
  import bids22_result_log_pkg::*;
#(
  parameter int DEPTH = B22_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clr,
  input  logic           push,
  input  logic           pop,
  input  bids22_result_t din,
  output bids22_result_t dout,
  output logic           full,
  output logic           empty,
  output logic [AW:0]    count
);

  bids22_result_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok & ~clr)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok & ~pop_ok)
        count <= count + 1'b1;
      else if (pop_ok & ~push_ok)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/bids22_result_log.sv
// bids22 round result logger: counts acked bids per round and
// queues one record per round-over edge for the host to drain.
module bids22_result_log
  import bids22_result_log_pkg::*;
#(
  parameter int DATAWIDTH  = B22_DW,
  parameter int NUMBIDDERS = B22_NB,
  parameter int DEPTH      = B22_DEPTH,
  parameter int RIDWIDTH   = B22_RIDW,
  localparam int WIDW =
    (NUMBIDDERS > 1) ? $clog2(NUMBIDDERS) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  round_active,
  input  logic                  round_over,
  input  logic [DATAWIDTH-1:0]  max_bid,
  input  logic [NUMBIDDERS-1:0] win,
  input  logic [NUMBIDDERS-1:0] bid_ack,
  input  logic                  clr,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [RIDWIDTH-1:0]   res_round_id,
  output logic [WIDW-1:0]       res_winner_id,
  output logic                  res_no_winner,
  output logic                  res_multi_win,
  output logic [DATAWIDTH-1:0]  res_max_bid,
  output logic [7:0]            res_bid_count,
  output logic [CW-1:0]         fifo_count,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  logic                round_over_q;
  logic                capture;
  logic                pop;
  logic                full;
  logic                empty;
  logic [7:0]          acc;
  logic [7:0]          acks;
  logic [7:0]          nwin;
  logic [8:0]          sum;
  logic [7:0]          acc_in;
  logic [WIDW-1:0]     wid;
  logic [RIDWIDTH-1:0] rid;
  bids22_result_t      rec;
  bids22_result_t      head;

  assign capture = round_over & ~round_over_q;
  assign pop     = res_valid & res_ready;

  always_comb begin
    acks = '0;
    nwin = '0;
    wid  = '0;
    for (int i = NUMBIDDERS - 1; i >= 0; i--) begin
      if (round_active) acks = acks + 8'(bid_ack[i]);
      nwin = nwin + 8'(win[i]);
      if (win[i]) wid = WIDW'(i);
    end
    sum    = {1'b0, acc} + {1'b0, acks};
    acc_in = sum[8] ? RESULT_CNT_MAX : sum[7:0];
  end

  always_comb begin
    rec           = '0;
    rec.round_id  = rid;
    rec.winner_id = wid;
    rec.no_winner = (win == '0);
    rec.multi_win = (nwin > 8'd1);
    rec.max_bid   = max_bid;
    rec.bid_count = acc_in;
  end

  bids22_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .push    (capture),
    .pop     (pop),
    .din     (rec),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_over_q <= 1'b0;
      acc          <= '0;
      rid          <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
    end else begin
      round_over_q <= round_over;
      if (clr) begin
        acc        <= '0;
        rid        <= '0;
        overflow   <= 1'b0;
        drop_count <= '0;
      end else begin
        acc <= capture ? 8'd0 : acc_in;
        if (capture) begin
          rid <= rid + 1'b1;
          if (full & ~pop) begin
            overflow <= 1'b1;
            if (drop_count != RESULT_CNT_MAX)
              drop_count <= drop_count + 1'b1;
          end
        end
      end
    end
  end

  // Head fields read as zero whenever nothing is queued.
  assign res_valid     = ~empty;
  assign res_round_id  = res_valid ? head.round_id  : '0;
  assign res_winner_id = res_valid ? head.winner_id : '0;
  assign res_no_winner = res_valid & head.no_winner;
  assign res_multi_win = res_valid & head.multi_win;
  assign res_max_bid   = res_valid ? head.max_bid   : '0;
  assign res_bid_count = res_valid ? head.bid_count : '0;

endmodule

// File: tb/tb_bids22_result_log.sv
// Self-checking bench for bids22_result_log against a queue model.
module tb_bids22_result_log;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        round_active = 1'b0;
  logic        round_over = 1'b0;
  logic [31:0] max_bid = '0;
  logic [2:0]  win = '0;
  logic [2:0]  bid_ack = '0;
  logic        clr = 1'b0;
  logic        res_ready = 1'b0;
  logic        res_valid;
  logic [15:0] res_round_id;
  logic [1:0]  res_winner_id;
  logic        res_no_winner;
  logic        res_multi_win;
  logic [31:0] res_max_bid;
  logic [7:0]  res_bid_count;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  int total = 0;
  int bad = 0;

  bids22_result_log dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .round_active  (round_active),
    .round_over    (round_over),
    .max_bid       (max_bid),
    .win           (win),
    .bid_ack       (bid_ack),
    .clr           (clr),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_round_id  (res_round_id),
    .res_winner_id (res_winner_id),
    .res_no_winner (res_no_winner),
    .res_multi_win (res_multi_win),
    .res_max_bid   (res_max_bid),
    .res_bid_count (res_bid_count),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int      rid;
    int      wid;
    bit      nw;
    bit      mw;
    longint  mb;
    int      bc;
  } rec_t;

  rec_t q[$];
  int   m_acc, m_rid, m_drops;
  bit   m_ovf, m_roq;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    rec_t r;
    bit   pop, cap;
    int   bc, wid, nw;
    if (!reset_n) begin
      q.delete();
      m_acc = 0; m_rid = 0; m_drops = 0;
      m_ovf = 0; m_roq = 0;
      return;
    end
    pop = (q.size() > 0) && res_ready;
    cap = round_over && !m_roq;
    m_roq = round_over;
    if (clr) begin
      q.delete();
      m_acc = 0; m_rid = 0; m_drops = 0; m_ovf = 0;
      return;
    end
    bc = m_acc + (round_active ? $countones(bid_ack) : 0);
    if (bc > 255) bc = 255;
    if (pop) void'(q.pop_front());
    if (cap) begin
      wid = 0; nw = 0;
      for (int i = 0; i < 3; i++)
        if (win[i]) begin
          if (nw == 0) wid = i;
          nw++;
        end
      r.rid = m_rid; r.wid = wid;
      r.nw = (nw == 0); r.mw = (nw > 1);
      r.mb = longint'(max_bid); r.bc = bc;
      if (q.size() == 8) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end else q.push_back(r);
      m_rid = (m_rid + 1) % 65536;
      m_acc = 0;
    end else m_acc = bc;
  endtask

  task automatic check_all();
    chk("valid", 64'(res_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("round_id", 64'(res_round_id), 64'(q[0].rid));
      chk("winner_id", 64'(res_winner_id), 64'(q[0].wid));
      chk("no_winner", 64'(res_no_winner), 64'(q[0].nw));
      chk("multi_win", 64'(res_multi_win), 64'(q[0].mw));
      chk("max_bid", 64'(res_max_bid), 64'(q[0].mb));
      chk("bid_count", 64'(res_bid_count), 64'(q[0].bc));
    end else begin
      chk("idle_id", 64'(res_round_id), 64'd0);
      chk("idle_bid", 64'(res_max_bid), 64'd0);
    end
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set(input bit ra, input bit ro,
                     input logic [31:0] mb, input logic [2:0] w,
                     input logic [2:0] ba, input bit cl,
                     input bit rdy);
    round_active = ra; round_over = ro; max_bid = mb;
    win = w; bid_ack = ba; clr = cl; res_ready = rdy;
  endtask

  task automatic round(input logic [2:0] w,
                       input logic [31:0] mb, input bit rdy);
    set(0, 1, mb, w, 3'b000, 0, rdy); tick();
    set(0, 0, 0, 0, 3'b000, 0, 0); tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", 64'(res_valid), 64'd0);
    reset_n = 1'b1;
    tick();

    set(1, 0, 0, 0, 3'b011, 0, 0); tick();
    set(1, 0, 0, 0, 3'b100, 0, 0); tick();
    set(1, 0, 0, 0, 3'b000, 0, 0); tick();
    set(0, 1, 40, 3'b010, 3'b000, 0, 0); tick();
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_wid", 64'(res_winner_id), 64'd1);
    chk("t1_bc", 64'(res_bid_count), 64'd3);
    chk("t1_mb", 64'(res_max_bid), 64'd40);
    chk("t1_rid", 64'(res_round_id), 64'd0);
    tick(); tick(); tick();
    chk("t2_count", 64'(fifo_count), 64'd1);

    set(0, 0, 0, 0, 0, 1, 0); tick();
    set(0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 9; i++) round(3'b001, 32'(100 + i), 0);
    chk("t3_count", 64'(fifo_count), 64'd8);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_drop", 64'(drop_count), 64'd1);
    chk("t3_head", 64'(res_round_id), 64'd0);

    round(3'b100, 32'd777, 1);
    chk("t4_count", 64'(fifo_count), 64'd8);
    chk("t4_drop", 64'(drop_count), 64'd1);
    set(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) tick();
    chk("t4_empty", 64'(res_valid), 64'd0);

    round(3'b000, 32'd5, 0);
    chk("t5_nw", 64'(res_no_winner), 64'd1);
    chk("t5_wid0", 64'(res_winner_id), 64'd0);
    set(0, 0, 0, 0, 0, 0, 1); tick();
    round(3'b110, 32'd6, 0);
    chk("t5_mw", 64'(res_multi_win), 64'd1);
    chk("t5_wid1", 64'(res_winner_id), 64'd1);
    set(0, 0, 0, 0, 0, 0, 1); tick();

    for (int i = 0; i < 3; i++) round(3'b010, 32'(i), 0);
    set(0, 1, 9, 3'b001, 0, 1, 1); tick();
    chk("t6_count", 64'(fifo_count), 64'd0);
    chk("t6_valid", 64'(res_valid), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    set(0, 0, 0, 0, 0, 0, 0); tick();
    round(3'b001, 32'd11, 0);
    chk("t6_rid", 64'(res_round_id), 64'd0);

    for (int n = 0; n < 600; n++) begin
      set($urandom_range(0, 3) != 0,
          $urandom_range(0, 5) == 0,
          $urandom, 3'($urandom), 3'($urandom),
          $urandom_range(0, 60) == 0,
          $urandom_range(0, 2) == 0);
      if (n == 300) reset_n = 1'b0;
      if (n == 302) reset_n = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
